// File: rtl/inagu_ctrl_pkg.sv
// mvu_pkg -- shared definitions for the INAGU controller slice.
//   inagu_state_t : controller FSM state encoding (IDLE, CLR, RUN, DRAIN, FIN)
//   DRAIN_W       : width of the post-run drain counter (DRAIN legal range 0..15)
package mvu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } inagu_state_t;

    localparam int unsigned DRAIN_W = 4;

endpackage

// File: rtl/inagu_ctrl_if.sv
// inagu_ctrl_if -- job-control bundle between a job issuer and inagu_ctrl.
//   master : drives start, jobcnt, stall, abort, shacc_done; observes status
//   slave  : the controller (agu_clr, agu_en, busy, done, acccnt outputs)
// Optional INAGU_CTRL_PERF_EN adds the stallcnt status signal.
interface inagu_ctrl_if #(
    parameter int unsigned BCNT = 16
);
    logic            start;
    logic [BCNT-1:0] jobcnt;
    logic            stall;
    logic            abort;
    logic            shacc_done;
    logic            agu_clr;
    logic            agu_en;
    logic            busy;
    logic            done;
    logic [BCNT-1:0] acccnt;
`ifdef INAGU_CTRL_PERF_EN
    logic [BCNT-1:0] stallcnt;

    modport master (
        output start, jobcnt, stall, abort, shacc_done,
        input  agu_clr, agu_en, busy, done, acccnt, stallcnt
    );
    modport slave (
        input  start, jobcnt, stall, abort, shacc_done,
        output agu_clr, agu_en, busy, done, acccnt, stallcnt
    );
`else
    modport master (
        output start, jobcnt, stall, abort, shacc_done,
        input  agu_clr, agu_en, busy, done, acccnt
    );
    modport slave (
        input  start, jobcnt, stall, abort, shacc_done,
        output agu_clr, agu_en, busy, done, acccnt
    );
`endif
endinterface

// File: rtl/inagu_ctrl_cnt_down.sv
// cnt_down -- loadable, enabled down-counter with zero flag.
//   clk, rst_n  : clock, asynchronous active-low reset (count -> 0)
//   i_load      : load i_load_val (has priority over i_en)
//   i_en        : decrement by one
//   o_zero      : count is zero
module cnt_down #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/inagu_ctrl.sv
// inagu_ctrl -- job controller for the input address generator.
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : inagu_ctrl_if.slave (start/jobcnt/stall/abort/shacc_done in;
//                agu_clr/agu_en/busy/done/acccnt out)
// Parameters: BCNT (counter width), DRAIN (post-run drain cycles, 0..15).
// Optional macro INAGU_CTRL_PERF_EN adds bus.stallcnt (saturating count of
// stalled RUN cycles, cleared on accepted start).
module inagu_ctrl
    import mvu_pkg::*;
#(
    parameter int unsigned BCNT  = 16,
    parameter int unsigned DRAIN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    inagu_ctrl_if.slave bus
);

    localparam logic [DRAIN_W-1:0] DRAIN_LD =
        (DRAIN > 0) ? DRAIN_W'(DRAIN - 1) : '0;

    inagu_state_t    r_state;
    inagu_state_t    w_state_nxt;
    logic            w_agu_en;
    logic            w_accept;
    logic            w_rem_load;
    logic            w_drain_load;
    logic            w_rem_zero;
    logic            w_drain_zero;
    logic [BCNT-1:0] w_rem_ld_val;
    logic [BCNT-1:0] r_acccnt;

    // Both counters are loaded with (count - 1) so that the zero flag marks
    // the final step / final drain cycle while that cycle is in progress.
    assign w_rem_ld_val = bus.jobcnt - BCNT'(1);

    cnt_down #(.WIDTH(BCNT)) u_rem (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_rem_load),
        .i_load_val (w_rem_ld_val),
        .i_en       (w_agu_en),
        .o_zero     (w_rem_zero)
    );

    cnt_down #(.WIDTH(DRAIN_W)) u_drain (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_drain_load),
        .i_load_val (DRAIN_LD),
        .i_en       (r_state == ST_DRAIN),
        .o_zero     (w_drain_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_agu_en     = 1'b0;
        w_accept     = 1'b0;
        w_rem_load   = 1'b0;
        w_drain_load = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    if (bus.jobcnt != '0) begin
                        w_rem_load  = 1'b1;
                        w_state_nxt = ST_CLR;
                    end else begin
                        w_state_nxt = ST_FIN;
                    end
                end
            end
            ST_CLR: begin
                w_state_nxt = bus.abort ? ST_FIN : ST_RUN;
            end
            ST_RUN: begin
                // Abort wins over a final step arriving in the same cycle.
                if (bus.abort) begin
                    w_state_nxt = ST_FIN;
                end else if (!bus.stall) begin
                    w_agu_en = 1'b1;
                    if (w_rem_zero) begin
                        w_drain_load = 1'b1;
                        w_state_nxt  = (DRAIN > 0) ? ST_DRAIN : ST_FIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.abort || w_drain_zero) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acccnt <= '0;
        end else if (w_rem_load) begin
            r_acccnt <= '0;
        end else if (((r_state == ST_RUN) || (r_state == ST_DRAIN)) && bus.shacc_done) begin
            r_acccnt <= r_acccnt + BCNT'(1);
        end
    end

`ifdef INAGU_CTRL_PERF_EN
    logic [BCNT-1:0] r_stallcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallcnt <= '0;
        end else if (w_accept) begin
            r_stallcnt <= '0;
        end else if ((r_state == ST_RUN) && bus.stall && (r_stallcnt != '1)) begin
            r_stallcnt <= r_stallcnt + BCNT'(1);
        end
    end

    assign bus.stallcnt = r_stallcnt;
`endif

    assign bus.agu_clr = (r_state == ST_CLR);
    assign bus.agu_en  = w_agu_en;
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = (r_state == ST_FIN);
    assign bus.acccnt  = r_acccnt;

endmodule

// File: doc/inagu_ctrl.md
INAGU_CTRL -- requirements
Module: inagu_ctrl

Interface
REQ-001 SHALL have parameter BCNT, default 16: bitwidth of job cycle count and accumulation counter.
REQ-002 SHALL have parameter DRAIN, default 2: post-run pipeline drain cycles, legal range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  job request, sampled only in IDLE.
REQ-006 SHALL have port jobcnt  input  BCNT  number of agu_en cycles for the job, latched on accepted start.
REQ-007 SHALL have port stall  input  1  datapath back-pressure; suppresses agu_en while high.
REQ-008 SHALL have port abort  input  1  terminate the current job.
REQ-009 SHALL have port shacc_done  input  1  accumulation-done pulse from the address generator.
REQ-010 SHALL have port agu_clr  output  1  clear to address generator.
REQ-011 SHALL have port agu_en  output  1  step enable to address generator.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle job-completion pulse.
REQ-014 SHALL have port acccnt  output  BCNT  shacc_done pulses counted in the current/last job.

Function
REQ-015 SHALL implement states IDLE, CLR, RUN, DRAIN, FIN.
REQ-016 IDLE: start=1 and jobcnt!=0 SHALL latch jobcnt into remaining counter, zero acccnt, go to CLR; start with jobcnt=0 SHALL go directly to FIN.
REQ-017 CLR: agu_clr=1 for exactly one cycle, agu_en=0, then RUN.
REQ-018 RUN: agu_en SHALL equal ~stall; each cycle with agu_en=1 SHALL decrement remaining by 1.
REQ-019 RUN: on the cycle agu_en=1 with remaining=1, next state SHALL be DRAIN (DRAIN>0) or FIN (DRAIN=0).
REQ-020 DRAIN: agu_en=0 for exactly DRAIN cycles regardless of stall, then FIN.
REQ-021 FIN: done=1 for one cycle, then IDLE; start is ignored in FIN.
REQ-022 acccnt SHALL increment by 1 on each cycle shacc_done=1 while in RUN or DRAIN, wrapping modulo 2^BCNT, and hold its value in IDLE.
REQ-023 abort=1 in CLR, RUN or DRAIN SHALL force next state FIN with agu_en=0 that same cycle; abort in IDLE or FIN has no effect.
REQ-024 abort and the final-step condition in the same cycle SHALL resolve as abort (agu_en=0, step not counted).
REQ-025 Latency start-accept to first agu_en SHALL be 2 cycles when stall=0; total busy cycles for unstalled job SHALL be jobcnt+DRAIN+2.
REQ-026 agu_clr, agu_en, done SHALL be registered outputs or decoded only from state and stall, with no combinational path from start.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, remaining=0, acccnt=0, agu_clr=0, agu_en=0, busy=0, done=0.
REQ-028 Reset mid-job SHALL discard the job without issuing done.
REQ-029 Deassertion of rst_n SHALL be treated as synchronous to clk; first transition possible on the following edge.

Configuration
REQ-030 Macro INAGU_CTRL_PERF_EN defined: SHALL add output stallcnt (BCNT) counting RUN cycles with stall=1, saturating at all-ones, zeroed on accepted start and on reset.
REQ-031 Macro INAGU_CTRL_PERF_EN undefined: stallcnt port and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-032 State encoding (enum of IDLE..FIN) SHALL live in shared package mvu_pkg as a typedef.
REQ-033 A sub-module cnt_down (loadable, enabled down-counter with zero flag, parameter width) SHALL implement remaining and drain counting, instantiated twice.
REQ-034 All logic SHALL reside in one clock domain with no latches.

Verification
REQ-035 jobcnt=5, stall=0, DRAIN=2: agu_clr at cycle 1 after start, agu_en cycles 2-6, done at cycle 9, busy 9 cycles.
REQ-036 jobcnt=4, stall high cycles 3-4: exactly 4 agu_en pulses, done delayed 2 cycles versus unstalled.
REQ-037 jobcnt=0: no agu_clr, no agu_en, done one cycle after start.
REQ-038 jobcnt=10, abort at 3rd agu_en cycle: agu_en low that cycle, done next cycle, only 2 steps issued.
REQ-039 shacc_done pulsed 3 times during RUN and once in IDLE: acccnt=3 after done.
REQ-040 rst_n low mid-RUN: all outputs zero immediately, no done; new start then runs normally.
